// File: rtl/byte_store_arbiter.sv
// Round-robin arbiter and glitch-safe write sequencer for a shared 8-bit latch byte store.
// Optional macro BYTE_STORE_LAST_ID_EN adds the last_id output (id of the last completed write).
module byte_store_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           mem_data,
  output logic                 mem_store,
  output logic                 busy
`ifdef BYTE_STORE_LAST_ID_EN
  ,
  output logic [ID_W-1:0]      last_id
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     pick;
  logic [ID_W-1:0]     next_ptr;
  logic [ID_W:0]       pick_sum;
  logic                pick_found;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [7:0]          sel_byte;

  // Rotating the doubled request vector puts rr_ptr at bit 0, so the first set bit
  // found scanning upward is the round-robin winner, wrap included.
  assign req_dbl = {req, req} >> rr_ptr;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_sum   = '0;
    pick       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_dbl[k]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (pick_sum >= (ID_W+1)'(NUM_REQ))
          pick_sum = pick_sum - (ID_W+1)'(NUM_REQ);
        pick = pick_sum[ID_W-1:0];
      end
    end
  end

  assign sel_byte = req_data[{pick, 3'b000} +: 8];

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++)
      win_onehot[i] = (win_id == ID_W'(i));
  end

  assign next_ptr = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each is valid for exactly the
  // cycle its state occupies and nothing reaches an output combinationally from req.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      win_id    <= '0;
      mem_data  <= 8'h00;
      mem_store <= 1'b0;
      ack       <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != IDLE);
      mem_store <= (state_d == STROBE);
      ack       <= (state_d == HOLD) ? win_onehot : '0;
      // mem_data only moves on IDLE->SETUP, keeping it stable around the strobe.
      if (state_q == IDLE && pick_found) begin
        win_id   <= pick;
        mem_data <= sel_byte;
      end
      if (state_q == HOLD)
        rr_ptr <= next_ptr;
    end
  end

`ifdef BYTE_STORE_LAST_ID_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_id <= '0;
    else if (state_d == HOLD)
      last_id <= win_id;
  end
`endif

endmodule

// File: tb/tb_byte_store_arbiter.sv
// Directed self-checking bench for byte_store_arbiter (NUM_REQ=4).
// Exercises reset, single write, round-robin wrap, back-to-back writes, data stability and abort.
module tb_byte_store_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           mem_data;
  logic                 mem_store;
  logic                 busy;
`ifdef BYTE_STORE_LAST_ID_EN
  logic [ID_W-1:0]      last_id;
`endif

  int checks = 0;
  int errors = 0;

  byte_store_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .mem_data  (mem_data),
    .mem_store (mem_store),
    .busy      (busy)
`ifdef BYTE_STORE_LAST_ID_EN
    ,
    .last_id   (last_id)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one write from the IDLE cycle in which the request is presented through
  // to the following IDLE cycle, checking every phase.
  task automatic xfer(input int id, input logic [7:0] b, input bit drop, input string tag);
    logic [NUM_REQ-1:0] exp_ack;
    exp_ack = NUM_REQ'(1) << id;
    tick();
    chk({tag, ".setup_busy"},  32'(busy),      32'd1);
    chk({tag, ".setup_data"},  32'(mem_data),  32'(b));
    chk({tag, ".setup_store"}, 32'(mem_store), 32'd0);
    chk({tag, ".setup_ack"},   32'(ack),       32'd0);
    tick();
    chk({tag, ".strobe_store"}, 32'(mem_store), 32'd1);
    chk({tag, ".strobe_data"},  32'(mem_data),  32'(b));
    chk({tag, ".strobe_ack"},   32'(ack),       32'd0);
    tick();
    chk({tag, ".hold_ack"},   32'(ack),       32'(exp_ack));
    chk({tag, ".hold_store"}, 32'(mem_store), 32'd0);
    chk({tag, ".hold_busy"},  32'(busy),      32'd1);
    chk({tag, ".hold_data"},  32'(mem_data),  32'(b));
`ifdef BYTE_STORE_LAST_ID_EN
    chk({tag, ".last_id"}, 32'(last_id), 32'(id));
`endif
    if (drop) req[id] = 1'b0;
    tick();
    chk({tag, ".idle_busy"},  32'(busy),      32'd0);
    chk({tag, ".idle_ack"},   32'(ack),       32'd0);
    chk({tag, ".idle_store"}, 32'(mem_store), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    #12;
    chk("rst.data",  32'(mem_data),  32'h00);
    chk("rst.store", 32'(mem_store), 32'd0);
    chk("rst.ack",   32'(ack),       32'd0);
    chk("rst.busy",  32'(busy),      32'd0);
`ifdef BYTE_STORE_LAST_ID_EN
    chk("rst.last_id", 32'(last_id), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // Single request from requester 2; rr_ptr becomes 3.
    req            = 4'b0100;
    req_data[23:16] = 8'hA5;
    xfer(2, 8'hA5, 1'b1, "single");

    // Serve 3, then 0 (wrap), then 3 again with both 0 and 3 pending.
    req             = 4'b1000;
    req_data[31:24] = 8'hC3;
    xfer(3, 8'hC3, 1'b0, "wrap_a");
    req             = 4'b1001;
    req_data[7:0]   = 8'h0F;
    xfer(0, 8'h0F, 1'b1, "wrap_b");
    req[0] = 1'b1;
    xfer(3, 8'hC3, 1'b1, "wrap_c");
    req = '0;

    // All requesters held high: strict 0,1,2,3,0 order, one write every 4 cycles.
    req      = 4'b1111;
    req_data = 32'h44332211;
    xfer(0, 8'h11, 1'b0, "all0");
    xfer(1, 8'h22, 1'b0, "all1");
    xfer(2, 8'h33, 1'b0, "all2");
    xfer(3, 8'h44, 1'b0, "all3");
    xfer(0, 8'h11, 1'b0, "all4");
    req = '0;

    // Stability: data and request change after capture; write still completes.
    req            = 4'b0010;
    req_data[15:8] = 8'h5A;
    tick();
    chk("stab.setup_data", 32'(mem_data), 32'h5A);
    req_data[15:8] = 8'hFF;
    req            = '0;
    tick();
    chk("stab.strobe_store", 32'(mem_store), 32'd1);
    chk("stab.strobe_data",  32'(mem_data),  32'h5A);
    tick();
    chk("stab.hold_ack", 32'(ack), 32'b0010);
    tick();
    chk("stab.idle_busy", 32'(busy), 32'd0);

    // Reset during STROBE aborts the write immediately.
    req             = 4'b0100;
    req_data[23:16] = 8'h77;
    tick();
    tick();
    chk("abort.strobe_store", 32'(mem_store), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort.store", 32'(mem_store), 32'd0);
    chk("abort.busy",  32'(busy),      32'd0);
    chk("abort.data",  32'(mem_data),  32'h00);
    chk("abort.ack",   32'(ack),       32'd0);
`ifdef BYTE_STORE_LAST_ID_EN
    chk("abort.last_id", 32'(last_id), 32'd0);
`endif
    req = '0;
    #2;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort.no_ack", 32'(ack), 32'd0);
    end
    req = 4'b0100;
    xfer(2, 8'h77, 1'b1, "retry");

    // Idle for 20 cycles.
    req = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle.store", 32'(mem_store), 32'd0);
      chk("idle.ack",   32'(ack),       32'd0);
      chk("idle.busy",  32'(busy),      32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
